display_sequencer: RTL and testbench

- Upstream stage of the 2's-complement 7-segment decoder.
- Holds a small programmable table of 4-bit 2's-complement values (-8..7) and steps through it at a divided-down rate.
- Presents the current value on `number`, which drives the decoder's `number` input directly.
- Start, hold/resume and stop controls; wrap-around at a run-time-selectable sequence length.

---
 rtl/display_seq_pkg.sv | 19 +
 rtl/tick_divider.sv | 42 ++++
 rtl/display_sequencer.sv | 170 +++++++++++++++++
 tb/tb_display_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/display_seq_pkg.sv
// display_seq_pkg
// Shared types and constants for the display sequencer slice.
//   state_t      : sequencer FSM states
//   NUM_W        : width of one 2's-complement table value
//   DEF_TICK_DIV : default clk cycles per sequence step
//   DEF_DEPTH    : default number of table entries
package display_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int NUM_W        = 4;
    localparam int DEF_TICK_DIV = 50_000_000;
    localparam int DEF_DEPTH    = 8;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Step-rate counter. It counts enabled cycles and raises tc on the cycle the
// count sits at TICK_DIV-1 while enabled; the count returns to 0 on that edge.
// When not enabled the count is frozen.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high reset
//   en    in  count enable
//   clr   in  synchronous clear (wins over en)
//   tc    out terminal count, combinational, qualified by en
import display_seq_pkg::*;

module tick_divider #(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc = en && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr || tc) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer
// Steps through a small programmable table of 4-bit 2's-complement values at
// one entry per TICK_DIV clocks and presents the current entry on number, which
// feeds the 7-segment decoder. Start / hold / stop control; the sequence wraps
// at a last index latched when starting from IDLE.
// Optional build macro: SEQ_REVERSE_EN adds the dir input (1 = descending).
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   wr_en      in  table write strobe
//   wr_addr    in  table write index
//   wr_data    in  value to store
//   start      in  IDLE: start at first entry; HOLD: resume
//   stop       in  RUN: hold; HOLD: back to IDLE (wins over start)
//   seq_last   in  last sequence index, latched on start from IDLE
//   dir        in  (SEQ_REVERSE_EN only) 1 = descending, sampled at each step
//   number     out current table value, registered
//   step_idx   out current table index
//   running    out high in RUN
//   step_pulse out one-cycle pulse when a step updates number
//   wrap_pulse out one-cycle pulse with step_pulse when the index wraps
import display_seq_pkg::*;

module display_sequencer #(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [NUM_W-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic [IDX_W-1:0] seq_last,
`ifdef SEQ_REVERSE_EN
    input  logic             dir,
`endif
    output logic [NUM_W-1:0] number,
    output logic [IDX_W-1:0] step_idx,
    output logic             running,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    state_t           state_q, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] last_q, last_nxt;
    logic [NUM_W-1:0] num_nxt;
    logic [NUM_W-1:0] tbl_q [DEPTH];
    logic             cnt_en, cnt_clr, tc;
    logic             wrap_step;
    logic             descend;

`ifdef SEQ_REVERSE_EN
    assign descend = dir;
`else
    assign descend = 1'b0;
`endif

    // Counter control depends only on registered state and inputs, so the
    // divider's tc never loops back into its own enable.
    assign cnt_en  = (state_q == ST_RUN) && !stop;
    assign cnt_clr = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && stop);

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .tc   (tc)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = step_idx;
        last_nxt  = last_q;
        wrap_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_nxt = '0;
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    last_nxt  = seq_last;
                    idx_nxt   = descend ? seq_last : '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_HOLD;
                end else if (tc) begin
                    if (descend) begin
                        if (step_idx == '0) begin
                            idx_nxt   = last_q;
                            wrap_step = 1'b1;
                        end else begin
                            idx_nxt = step_idx - IDX_W'(1);
                        end
                    end else begin
                        if (step_idx == last_q) begin
                            idx_nxt   = '0;
                            wrap_step = 1'b1;
                        end else begin
                            idx_nxt = step_idx + IDX_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end else if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // A write landing on the entry about to be shown bypasses the table, so
    // number always matches table[step_idx] one cycle later.
    always_comb begin
        num_nxt = tbl_q[idx_nxt];
        if (wr_en && (wr_addr == idx_nxt)) begin
            num_nxt = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_idx   <= '0;
            last_q     <= '0;
            number     <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            step_idx   <= idx_nxt;
            last_q     <= last_nxt;
            number     <= num_nxt;
            step_pulse <= tc;
            wrap_pulse <= wrap_step;
        end
    end

    // NOTE: the table is small and must read as all-zero after reset, so it is
    // built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer
// Directed, table-driven bench for display_sequencer with TICK_DIV=4, DEPTH=8.
// Each vector applies inputs for one clock and lists the outputs expected after
// that edge. Reset behaviour is checked by hand-written sequences.
module tb_display_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;
    localparam int IDX_W    = 3;

    typedef struct {
        logic             wr_en;
        logic [IDX_W-1:0] wr_addr;
        logic [3:0]       wr_data;
        logic             start;
        logic             stop;
        logic [IDX_W-1:0] seq_last;
        logic             dir;
        logic [3:0]       e_num;
        logic [IDX_W-1:0] e_idx;
        logic             e_run;
        logic             e_step;
        logic             e_wrap;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [3:0]       wr_data = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [IDX_W-1:0] seq_last = '0;
    logic             dir = 1'b0;
    logic [3:0]       number;
    logic [IDX_W-1:0] step_idx;
    logic             running;
    logic             step_pulse;
    logic             wrap_pulse;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    display_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .seq_last  (seq_last),
`ifdef SEQ_REVERSE_EN
        .dir       (dir),
`endif
        .number    (number),
        .step_idx  (step_idx),
        .running   (running),
        .step_pulse(step_pulse),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input int wa, input logic [3:0] wd,
                       input logic st, input logic sp, input int sl, input logic dr,
                       input logic [3:0] num, input int idx, input logic run,
                       input logic stp, input logic wrp);
        vec_t v;
        v.wr_en = we; v.wr_addr = IDX_W'(wa); v.wr_data = wd;
        v.start = st; v.stop = sp; v.seq_last = IDX_W'(sl); v.dir = dr;
        v.e_num = num; v.e_idx = IDX_W'(idx); v.e_run = run;
        v.e_step = stp; v.e_wrap = wrp;
        vq.push_back(v);
    endtask

    // Idle cycle shorthand: no write, no control, expected outputs given.
    task automatic idle(input logic [3:0] num, input int idx, input logic run,
                        input logic stp, input logic wrp);
        add(0, 0, 4'h0, 0, 0, 0, dir, num, idx, run, stp, wrp);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] num, input int idx,
                                 input logic run, input logic stp, input logic wrp);
        check({tag, " number"},     8'(number),     8'(num));
        check({tag, " step_idx"},   8'(step_idx),   8'(idx));
        check({tag, " running"},    8'(running),    8'(run));
        check({tag, " step_pulse"}, 8'(step_pulse), 8'(stp));
        check({tag, " wrap_pulse"}, 8'(wrap_pulse), 8'(wrp));
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            wr_en = vq[i].wr_en; wr_addr = vq[i].wr_addr; wr_data = vq[i].wr_data;
            start = vq[i].start; stop = vq[i].stop; seq_last = vq[i].seq_last;
            dir = vq[i].dir;
            @(posedge clk);
            #1;
            check_outputs($sformatf("%s v%0d", tag, i), vq[i].e_num, int'(vq[i].e_idx),
                          vq[i].e_run, vq[i].e_step, vq[i].e_wrap);
        end
        wr_en = 0; start = 0; stop = 0;
        vq.delete();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check_outputs("reset", 4'h0, 0, 0, 0, 0);

        // Load 3, -2, 7, -8 and run a 4-entry ascending sequence.
        add(1, 0, 4'h3, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0);
        add(1, 1, 4'hE, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0);
        add(1, 2, 4'h7, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0);
        add(1, 3, 4'h8, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 3, 0, 4'h3, 0, 1, 0, 0);      // start
        idle(4'h3, 0, 1, 0, 0); idle(4'h3, 0, 1, 0, 0); idle(4'h3, 0, 1, 0, 0);
        idle(4'hE, 1, 1, 1, 0);                              // first step, 4 cycles
        idle(4'hE, 1, 1, 0, 0); idle(4'hE, 1, 1, 0, 0); idle(4'hE, 1, 1, 0, 0);
        idle(4'h7, 2, 1, 1, 0);
        idle(4'h7, 2, 1, 0, 0); idle(4'h7, 2, 1, 0, 0); idle(4'h7, 2, 1, 0, 0);
        idle(4'h8, 3, 1, 1, 0);
        idle(4'h8, 3, 1, 0, 0); idle(4'h8, 3, 1, 0, 0); idle(4'h8, 3, 1, 0, 0);
        idle(4'h3, 0, 1, 1, 1);                              // wrap to entry 0
        // Stop two cycles into a step, hold ten cycles, resume.
        idle(4'h3, 0, 1, 0, 0); idle(4'h3, 0, 1, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0);      // stop -> HOLD
        for (int k = 0; k < 10; k++) idle(4'h3, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 5, 0, 4'h3, 0, 1, 0, 0);      // resume, seq_last ignored
        idle(4'h3, 0, 1, 0, 0);
        idle(4'hE, 1, 1, 1, 0);                              // step 2 cycles after resume
        // start in RUN ignored; start+stop goes to HOLD; stop in HOLD to IDLE.
        add(0, 0, 4'h0, 1, 0, 0, 0, 4'hE, 1, 1, 0, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 4'hE, 1, 0, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0);      // stop in IDLE ignored
        // Single-entry sequence with table[0]=5.
        add(1, 0, 4'h5, 0, 0, 0, 0, 4'h5, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 0, 0, 4'h5, 0, 1, 0, 0);
        idle(4'h5, 0, 1, 0, 0); idle(4'h5, 0, 1, 0, 0); idle(4'h5, 0, 1, 0, 0);
        idle(4'h5, 0, 1, 1, 1);
        idle(4'h5, 0, 1, 0, 0); idle(4'h5, 0, 1, 0, 0); idle(4'h5, 0, 1, 0, 0);
        idle(4'h5, 0, 1, 1, 1);
        // Write 0x9 to the displayed entry mid-run.
        add(1, 0, 4'h9, 0, 0, 0, 0, 4'h9, 0, 1, 0, 0);
        idle(4'h9, 0, 1, 0, 0); idle(4'h9, 0, 1, 0, 0);
        idle(4'h9, 0, 1, 1, 1);
        run_vectors("main");

        // Asynchronous reset mid-run, right after a step pulse: no clock edge.
        #1 reset = 1'b1;
        #1;
        check_outputs("async_reset", 4'h0, 0, 0, 0, 0);
        #1 reset = 1'b0;

        // Table must read back as zero after reset (entries were 9, E).
        idle(4'h0, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 1, 0, 4'h0, 0, 1, 0, 0);
        idle(4'h0, 0, 1, 0, 0); idle(4'h0, 0, 1, 0, 0); idle(4'h0, 0, 1, 0, 0);
        idle(4'h0, 1, 1, 1, 0);
        run_vectors("post_reset");

`ifdef SEQ_REVERSE_EN
        do_reset();
        add(1, 0, 4'h3, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);
        add(1, 1, 4'hE, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);
        add(1, 2, 4'h7, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);
        add(1, 3, 4'h8, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 3, 1, 4'h8, 3, 1, 0, 0);      // start descending at 3
        dir = 1'b1;
        for (int k = 0; k < 3; k++) idle(4'h8, 3, 1, 0, 0);
        idle(4'h7, 2, 1, 1, 0);
        for (int k = 0; k < 3; k++) idle(4'h7, 2, 1, 0, 0);
        idle(4'hE, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) idle(4'hE, 1, 1, 0, 0);
        idle(4'h3, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) idle(4'h3, 0, 1, 0, 0);
        idle(4'h8, 3, 1, 1, 1);                              // wrap 0 -> 3
        // Flip to ascending mid-run: from 3 (the last index) wraps to 0.
        dir = 1'b0;
        for (int k = 0; k < 3; k++) idle(4'h8, 3, 1, 0, 0);
        idle(4'h3, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) idle(4'h3, 0, 1, 0, 0);
        idle(4'hE, 1, 1, 1, 0);
        run_vectors("reverse");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
